// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_SIZE      = 64;
  localparam int DEF_NUM_REQ   = 2;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

endpackage

// File: rtl/memory.sv
// Single-port synchronous word memory: write at the clock edge, registered read.
module memory #(
  parameter  int WIDTH   = 16,
  parameter  int SIZE    = 64,
  localparam int LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic [LOGSIZE-1:0] addr,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               wr_en,
  output logic [WIDTH-1:0]   data_out
);

  logic [WIDTH-1:0] mem_q [SIZE];

  // NOTE: storage arrays get no reset; contents survive a reset by design.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[addr] <= data_in;
    data_out <= mem_q[addr];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NUM_REQ requesters,
// with a bounded burst lock that lets one requester hold the port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int WIDTH     = DEF_WIDTH,
  parameter  int SIZE      = DEF_SIZE,
  parameter  int NUM_REQ   = DEF_NUM_REQ,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int LOGSIZE   = $clog2(SIZE),
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ-1:0]                req_lock,
  input  logic [NUM_REQ-1:0][LOGSIZE-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [WIDTH-1:0]                  rsp_rdata,
  output logic [IDW-1:0]                    grant_id
);

  arb_state_t           st_q, st_d;
  logic [IDW-1:0]       last_q, last_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [3:0]           burst_q, burst_d;
  logic [NUM_REQ-1:0]   pend_q, pend_d;

  logic [IDW:0]         pick;
  logic [IDW-1:0]       sel;
  logic                 accept;
  logic [LOGSIZE-1:0]   mem_addr;
  logic [WIDTH-1:0]     mem_wdata;
  logic [WIDTH-1:0]     mem_rdata;
  logic                 mem_we;

  // Returns {found, index}; scans from last+1 so the lowest offset wins.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDW-1:0]     last);
    logic [IDW:0]   res;
    logic [IDW-1:0] cand;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDW'((int'(last) + k) % NUM_REQ);
      if (valid[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  assign pick = rr_pick(req_valid, last_q);

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    accept    = 1'b0;
    sel       = '0;
    req_ready = '0;
    if (!reset) begin
      unique case (st_q)
        ARB_IDLE: begin
          accept = pick[IDW];
          sel    = pick[IDW-1:0];
        end
        ARB_OWN: begin
          accept = req_valid[owner_q];
          sel    = owner_q;
        end
        default: ;
      endcase
    end
    if (accept) req_ready[sel] = 1'b1;
  end

  assign mem_addr  = req_addr[sel];
  assign mem_wdata = req_wdata[sel];
  assign mem_we    = accept & req_we[sel];

  always_comb begin
    st_d    = st_q;
    last_d  = last_q;
    owner_d = owner_q;
    grant_d = grant_q;
    burst_d = burst_q;
    pend_d  = '0;
    if (accept) begin
      last_d  = sel;
      grant_d = sel;
      if (!req_we[sel]) pend_d[sel] = 1'b1;
    end
    unique case (st_q)
      ARB_IDLE: begin
        if (accept && req_lock[sel] && MAX_BURST > 1) begin
          st_d    = ARB_OWN;
          owner_d = sel;
          burst_d = 4'd1;
        end
      end
      ARB_OWN: begin
        if (accept && req_lock[owner_q] && (int'(burst_q) + 1 < MAX_BURST)) begin
          burst_d = burst_q + 4'd1;
        end else begin
          // Forced rotation or idle owner: give everyone else a chance.
          st_d    = ARB_IDLE;
          burst_d = '0;
        end
      end
      default: st_d = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= ARB_IDLE;
      last_q  <= IDW'(NUM_REQ - 1);
      owner_q <= '0;
      grant_q <= '0;
      burst_q <= '0;
      pend_q  <= '0;
    end else begin
      st_q    <= st_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      pend_q  <= pend_d;
    end
  end

  assign rsp_valid = pend_q;
  assign rsp_rdata = (|pend_q) ? mem_rdata : '0;
  assign grant_id  = grant_q;

  memory #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_mem (
    .clk      (clk),
    .addr     (mem_addr),
    .data_in  (mem_wdata),
    .wr_en    (mem_we),
    .data_out (mem_rdata)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant expectations per step, read responses via a scoreboard queue.
module tb_mem_arbiter;

  typedef struct {
    logic [1:0]  v;
    logic [15:0] d;
  } rsp_t;

  logic             clk;
  logic             reset;
  logic [1:0]       req_valid;
  logic [1:0]       req_we;
  logic [1:0]       req_lock;
  logic [1:0][5:0]  req_addr;
  logic [1:0][15:0] req_wdata;
  logic [1:0]       req_ready;
  logic [1:0]       rsp_valid;
  logic [15:0]      rsp_rdata;
  logic [0:0]       grant_id;

  int          errors = 0;
  int          checks = 0;
  rsp_t        pend_q[$];
  logic [15:0] model_mem [64];
  logic [0:0]  exp_gid;

  mem_arbiter #(
    .WIDTH     (16),
    .SIZE      (64),
    .NUM_REQ   (2),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic we, input logic lock,
                       input logic [5:0] a, input logic [15:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_lock[i]  = lock;
    req_addr[i]  = a;
    req_wdata[i] = d;
  endtask

  // One clock cycle: compare grant, grant_id and any due response, then log this cycle's accept.
  task automatic step(input logic [1:0] exp_rdy, input string tag);
    rsp_t e;
    int   g;
    @(negedge clk);
    check(32'(req_ready), 32'(exp_rdy), {tag, "/ready"});
    check(32'(grant_id), 32'(exp_gid), {tag, "/grant_id"});
    if (pend_q.size() > 0) begin
      e = pend_q.pop_front();
      check(32'(rsp_valid), 32'(e.v), {tag, "/rsp_valid"});
      check(32'(rsp_rdata), 32'(e.d), {tag, "/rsp_rdata"});
    end else begin
      check(32'(rsp_valid), 32'd0, {tag, "/rsp_valid_idle"});
      check(32'(rsp_rdata), 32'd0, {tag, "/rsp_rdata_idle"});
    end
    if (exp_rdy != 2'b00) begin
      g = exp_rdy[1] ? 1 : 0;
      if (req_we[g]) model_mem[req_addr[g]] = req_wdata[g];
      else pend_q.push_back('{v: exp_rdy, d: model_mem[req_addr[g]]});
      exp_gid = 1'(g);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 2'b01;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    exp_gid   = '0;

    // Reset state, with a request already pending that must not be granted.
    #3;
    check(32'(req_ready), 32'd0, "reset/ready");
    check(32'(rsp_valid), 32'd0, "reset/rsp_valid");
    check(32'(rsp_rdata), 32'd0, "reset/rsp_rdata");
    check(32'(grant_id), 32'd0, "reset/grant_id");
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b0;
    @(posedge clk);
    #1;

    // Single write then read-back by requester 0.
    drive(0, 1, 1, 0, 6'd5, 16'hBEEF);
    step(2'b01, "wr5");
    drive(0, 1, 0, 0, 6'd5, 16'h0);
    step(2'b01, "rd5");
    drive(0, 0, 0, 0, 6'd0, 16'h0);
    step(2'b00, "rd5_rsp");

    // Preload addresses 1 and 2 from different requesters.
    drive(0, 1, 1, 0, 6'd1, 16'h0011);
    step(2'b01, "pre1");
    drive(0, 0, 0, 0, 6'd0, 16'h0);
    drive(1, 1, 1, 0, 6'd2, 16'h0022);
    step(2'b10, "pre2");

    // Round-robin contention: both read continuously.
    drive(0, 1, 0, 0, 6'd1, 16'h0);
    drive(1, 1, 0, 0, 6'd2, 16'h0);
    step(2'b01, "rr0");
    step(2'b10, "rr1");
    step(2'b01, "rr2");
    step(2'b10, "rr3");

    // Burst lock: req0 wins first, then req1 holds for exactly MAX_BURST grants.
    drive(1, 1, 0, 1, 6'd2, 16'h0);
    step(2'b01, "bl_pre");
    step(2'b10, "bl1");
    step(2'b10, "bl2");
    step(2'b10, "bl3");
    step(2'b10, "bl4");
    step(2'b01, "bl_rot");
    drive(0, 0, 0, 0, 6'd0, 16'h0);
    drive(1, 0, 0, 0, 6'd0, 16'h0);
    step(2'b00, "bl_drain");

    // Owner drops valid while locked: one dead cycle, then req1.
    drive(0, 1, 1, 1, 6'd10, 16'hAAAA);
    step(2'b01, "od_lock");
    drive(0, 0, 0, 0, 6'd0, 16'h0);
    drive(1, 1, 0, 0, 6'd10, 16'h0);
    step(2'b00, "od_gap");
    step(2'b10, "od_rd");
    drive(1, 0, 0, 0, 6'd0, 16'h0);
    step(2'b00, "od_rsp");

    // Write at T by req0, read of the same address at T+1 by req1.
    drive(0, 1, 1, 0, 6'd63, 16'h1234);
    step(2'b01, "wr63");
    drive(0, 0, 0, 0, 6'd0, 16'h0);
    drive(1, 1, 0, 0, 6'd63, 16'h0);
    step(2'b10, "rd63");
    drive(1, 0, 0, 0, 6'd0, 16'h0);
    step(2'b00, "rd63_rsp");

    // Reset in the cycle after a read accept drops the response.
    drive(0, 1, 0, 0, 6'd5, 16'h0);
    step(2'b01, "mr_rd");
    reset = 1'b1;
    pend_q.delete();
    exp_gid = '0;
    #1;
    check(32'(rsp_valid), 32'd0, "mr/rsp_valid");
    check(32'(rsp_rdata), 32'd0, "mr/rsp_rdata");
    check(32'(req_ready), 32'd0, "mr/ready");
    check(32'(grant_id), 32'd0, "mr/grant_id");
    @(negedge clk);
    req_valid = '0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 1, 0, 0, 6'd5, 16'h0);
    drive(1, 1, 0, 0, 6'd2, 16'h0);
    step(2'b01, "mr_prio0");
    drive(0, 0, 0, 0, 6'd0, 16'h0);
    step(2'b10, "mr_next1");
    drive(1, 0, 0, 0, 6'd0, 16'h0);
    step(2'b00, "mr_drain");

    check(32'(pend_q.size()), 32'd0, "scoreboard_empty");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one single-port synchronous `memory` instance between `NUM_REQ` requesters. It accepts one read or write per cycle and returns read data one cycle after the grant. It also supports a bounded burst lock so a requester can hold the port for consecutive accesses. It sits between the datapath clients and the word memory, and it is the only driver of the memory's `addr`, `data_in` and `wr_en`.

## Interface
- `WIDTH`, 16: bits per word; passed to the memory.
- `SIZE`, 64: words in the memory; `LOGSIZE = $clog2(SIZE)` is a localparam.
- `NUM_REQ`, 2: number of requesters; legal range is 2..8. `IDW = $clog2(NUM_REQ)` is a localparam.
- `MAX_BURST`, 4: maximum consecutive grants under lock; legal range is 1..16.
- `clk`  in  1  the single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_we`  in  NUM_REQ  per-requester request type: 1 = write, 0 = read.
- `req_lock`  in  NUM_REQ  per-requester request to keep the grant for the next cycle.
- `req_addr`  in  NUM_REQ×LOGSIZE  per-requester word address (packed array).
- `req_wdata`  in  NUM_REQ×WIDTH  per-requester write data (packed array).
- `req_ready`  out  NUM_REQ  grant; one-hot or zero. A request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  NUM_REQ  read-data valid, one-hot or zero.
- `rsp_rdata`  out  WIDTH  read data; forced to 0 whenever `rsp_valid` is all-zero.
- `grant_id`  out  IDW  index of the last accepted requester, registered.

## Operation
- State machine `st` has two states, IDLE and OWN. It also holds these registers: `last_id` (IDW bits), `owner` (IDW bits), `burst_cnt` (4 bits) and `rsp_pend` (NUM_REQ bits).
- **IDLE state**
  - Priority search starts at `(last_id+1) mod NUM_REQ` and wraps.
  - The first requester with `req_valid` set gets `req_ready`.
  - With no valid requester, `req_ready` is 0 and the memory sees `wr_en=0`.
- **OWN state**
  - Only `owner` can receive `req_ready`, and only when `req_valid[owner]` is set.
  - All other requesters see `req_ready=0`.
- **Memory drive, same cycle as the accept**
  - `addr`, `data_in` and `wr_en` come combinationally from the granted requester's signals.
  - `wr_en` is 0 when there is no accept.
- **On accept of requester i**
  - `last_id <= i`
  - `grant_id <= i`
  - `rsp_pend <= (1<<i)` if the access is a read, else 0.
- **State transitions, evaluated at the clock edge**
  - IDLE→OWN: accept with `req_lock[i]=1` and `MAX_BURST>1`. Sets `owner=i` and `burst_cnt=1`.
  - OWN→OWN: owner accepted with `req_lock=1` and `burst_cnt+1 < MAX_BURST`. Increments `burst_cnt`.
  - OWN→IDLE, forced rotation: owner accepted and either `req_lock=0` or `burst_cnt+1 == MAX_BURST`.
  - OWN→IDLE, idle owner: `req_valid[owner]=0`. No access happens that cycle; other requesters wait one cycle.
- **Read response**
  - `rsp_valid = rsp_pend`.
  - `rsp_rdata` is the memory `data_out` gated by `|rsp_pend`.
- **Ordering**
  - Each cycle has at most one access, so there are no read/write collisions.
  - A write at cycle T followed by a read of the same address at T+1 returns the new data.
- **Address width**: addresses are LOGSIZE bits. When SIZE is not a power of two, out-of-range addresses are passed through unchecked; it is the requester's responsibility to stay in range.

## Timing
- **Reset values**
  - Outputs: `req_ready=0` (forced while `reset` is high), `rsp_valid=0`, `rsp_rdata=0`, `grant_id=0`.
  - Internal: `st=IDLE`, `last_id=NUM_REQ-1` (so requester 0 has first priority), `burst_cnt=0`, `owner=0`.
- **Latency**
  - `req_ready` is combinational from `req_valid` and state.
  - Read data arrives exactly one cycle after the accept.
  - Writes complete at the accept edge.
- **Throughput**: one access per cycle, with back-to-back grants to different requesters allowed.
- **Reset mid-operation**
  - A pending read response is dropped (`rsp_valid` is 0 after reset).
  - A lock is released.
  - Memory contents are not reset.
- **Handshake rule**: a requester must hold `req_valid`, `req_we`, `req_addr` and `req_wdata` stable until it sees `req_ready`.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;`
  - the default constants for WIDTH, SIZE, NUM_REQ and MAX_BURST.
- Natural sub-module: the existing `memory` block, instantiated once as `u_mem` with WIDTH and SIZE passed through.
- The round-robin priority search is a function inside the arbiter, not a separate module.

## Test plan
- **Reset then single write/read**: reset, then req0 writes 0xBEEF to address 5, then req0 reads address 5. Expect `rsp_valid=2'b01` and `rsp_rdata=0xBEEF` one cycle after the read accept.
- **Round-robin contention**: both requesters read continuously from addresses 1 and 2 (preloaded 0x0011 and 0x0022). Expect grants alternating 0,1,0,1 starting with 0, and `rsp_rdata` alternating 0x0011 and 0x0022.
- **Burst lock with MAX_BURST=4**: req1 holds `req_lock=1` and `req_valid=1` while req0 is also valid. Expect req1 granted exactly 4 consecutive cycles, then req0 granted.
- **Owner drops valid under lock**: req0 locks, then drops `req_valid` while req1 is valid. Expect one cycle with no grant, then req1 granted.
- **Write-then-read back-to-back**: req0 writes 0x1234 to address 63 at T, and req1 reads address 63 at T+1. Expect `rsp_valid=2'b10` and `rsp_rdata=0x1234` at T+2.
- **Reset mid-read**: assert reset in the cycle after a read accept. Expect `rsp_valid=0` and `rsp_rdata=0` immediately; after release, requester 0 has priority again.
